// File: rtl/dmac_arb_pkg.sv
// Shared types and sizing helpers for the DMA control-port arbiter.
package dmac_arb_pkg;

    localparam int unsigned NB_INIT_DEF = 10;
    localparam int unsigned CTRL_ADDR_W = 32;
    localparam int unsigned CTRL_DATA_W = 32;
    localparam int unsigned CTRL_BE_W   = CTRL_DATA_W / 8;
    localparam int unsigned MAX_OUT_DEF = 4;

    // Index width, never below one bit
    function automatic int unsigned idx_width(input int unsigned nb_init);
        return (nb_init > 1) ? $clog2(nb_init) : 1;
    endfunction

    localparam int unsigned IDX_W = idx_width(NB_INIT_DEF);

    typedef logic [IDX_W-1:0] init_idx_t;

    typedef struct packed {
        logic [CTRL_ADDR_W-1:0] add;
        logic                   wen;
        logic [CTRL_BE_W-1:0]   be;
        logic [CTRL_DATA_W-1:0] data;
    } ctrl_req_t;

endpackage

// File: rtl/dmac_arb_id_fifo.sv
// In-order FIFO of issuing-initiator indices; head names the owner of the next response.
module dmac_arb_id_fifo
    import dmac_arb_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_OUT_DEF,
    parameter type         T     = init_idx_t,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  T                 data_i,
    input  logic             pop_i,
    output T                 head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_eff, pop_eff;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pushing while full is only legal when the head leaves in the same cycle
    assign pop_eff  = pop_i & ~empty_o;
    assign push_eff = push_i & (~full_o | pop_eff);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_eff) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push_eff && !pop_eff) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_eff && !push_eff) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dmac_ctrl_arbiter.sv
// Round-robin funnel of NB_INIT control initiators onto the single DMA control target,
// with responses routed back in issue order.
module dmac_ctrl_arbiter
    import dmac_arb_pkg::*;
#(
    parameter int unsigned NB_INIT         = NB_INIT_DEF,
    parameter int unsigned ADDR_WIDTH      = CTRL_ADDR_W,
    parameter int unsigned DATA_WIDTH      = CTRL_DATA_W,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned MAX_OUTSTANDING = MAX_OUT_DEF,
    localparam int unsigned ID_W           = idx_width(NB_INIT)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NB_INIT-1:0]                   init_req_i,
    input  logic [NB_INIT-1:0][ADDR_WIDTH-1:0]   init_add_i,
    input  logic [NB_INIT-1:0]                   init_wen_i,
    input  logic [NB_INIT-1:0][BE_WIDTH-1:0]     init_be_i,
    input  logic [NB_INIT-1:0][DATA_WIDTH-1:0]   init_data_i,
    output logic [NB_INIT-1:0]                   init_gnt_o,
    output logic [NB_INIT-1:0]                   init_r_valid_o,
    output logic [NB_INIT-1:0][DATA_WIDTH-1:0]   init_r_data_o,
    output logic [NB_INIT-1:0]                   init_r_opc_o,
    output logic                                 tgt_req_o,
    output logic [ADDR_WIDTH-1:0]                tgt_add_o,
    output logic                                 tgt_wen_o,
    output logic [BE_WIDTH-1:0]                  tgt_be_o,
    output logic [DATA_WIDTH-1:0]                tgt_data_o,
    output logic [ID_W-1:0]                      tgt_id_o,
    input  logic                                 tgt_gnt_i,
    input  logic                                 tgt_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                tgt_r_data_i,
    input  logic                                 tgt_r_opc_i,
    output logic                                 busy_o,
    output logic                                 err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef logic [ID_W-1:0] idx_t;

    idx_t             rr_q, rr_d;
    idx_t             winner, sel, head;
    logic             found;
    int unsigned      pos;
    logic             err_q, err_d;
    logic             can_issue, handshake, pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    ctrl_req_t        sel_req;

    // Priority scan starting at rr_q, wrapping modulo NB_INIT
    always_comb begin
        found  = 1'b0;
        winner = '0;
        pos    = 0;
        for (int unsigned i = 0; i < NB_INIT; i++) begin
            pos = 32'(rr_q) + i;
            if (pos >= NB_INIT) begin
                pos = pos - NB_INIT;
            end
            if (!found && init_req_i[ID_W'(pos)]) begin
                found  = 1'b1;
                winner = ID_W'(pos);
            end
        end
    end

    // A response in the same cycle frees a slot, so issue is allowed even when full
    assign can_issue = ~fifo_full | tgt_r_valid_i;
    assign tgt_req_o = rst_ni & found & can_issue;
    assign handshake = tgt_req_o & tgt_gnt_i;
    assign pop       = rst_ni & tgt_r_valid_i & ~fifo_empty;

    assign sel = tgt_req_o ? winner : '0;

    always_comb begin
        sel_req      = '0;
        sel_req.add  = CTRL_ADDR_W'(init_add_i[sel]);
        sel_req.wen  = init_wen_i[sel];
        sel_req.be   = CTRL_BE_W'(init_be_i[sel]);
        sel_req.data = CTRL_DATA_W'(init_data_i[sel]);
    end

    assign tgt_add_o  = ADDR_WIDTH'(sel_req.add);
    assign tgt_wen_o  = sel_req.wen;
    assign tgt_be_o   = BE_WIDTH'(sel_req.be);
    assign tgt_data_o = DATA_WIDTH'(sel_req.data);
    assign tgt_id_o   = sel;

    assign init_gnt_o     = handshake ? (NB_INIT'(1) << winner) : '0;
    assign init_r_valid_o = pop ? (NB_INIT'(1) << head) : '0;
    assign init_r_data_o  = {NB_INIT{tgt_r_data_i}};
    assign init_r_opc_o   = {NB_INIT{tgt_r_opc_i}};

    assign busy_o = (fifo_count != '0);
    assign err_o  = err_q;

    always_comb begin
        rr_d  = rr_q;
        err_d = err_q | (tgt_r_valid_i & fifo_empty);
        if (handshake) begin
            rr_d = (winner == ID_W'(NB_INIT - 1)) ? '0 : winner + ID_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    dmac_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (idx_t)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .data_i  (winner),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_dmac_ctrl_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_dmac_ctrl_arbiter;

    localparam int N    = 10;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]         req, wen;
    logic [N-1:0][31:0]   add, data;
    logic [N-1:0][3:0]    be;
    logic                 tgt_gnt, tgt_rv, tgt_opc;
    logic [31:0]          tgt_rdata;

    logic [N-1:0]         gnt, rvalid, r_opc;
    logic [N-1:0][31:0]   r_data;
    logic                 treq, twen, busy, err;
    logic [31:0]          tadd, tdata;
    logic [3:0]           tbe, tid;

    dmac_ctrl_arbiter dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .init_req_i     (req),
        .init_add_i     (add),
        .init_wen_i     (wen),
        .init_be_i      (be),
        .init_data_i    (data),
        .init_gnt_o     (gnt),
        .init_r_valid_o (rvalid),
        .init_r_data_o  (r_data),
        .init_r_opc_o   (r_opc),
        .tgt_req_o      (treq),
        .tgt_add_o      (tadd),
        .tgt_wen_o      (twen),
        .tgt_be_o       (tbe),
        .tgt_data_o     (tdata),
        .tgt_id_o       (tid),
        .tgt_gnt_i      (tgt_gnt),
        .tgt_r_valid_i  (tgt_rv),
        .tgt_r_data_i   (tgt_rdata),
        .tgt_r_opc_i    (tgt_opc),
        .busy_o         (busy),
        .err_o          (err)
    );

    // Reference model: queue of (issuer, issue cycle), round-robin pointer, sticky error
    typedef struct {
        int idx;
        int cyc;
    } ent_t;

    ent_t q[$];
    int   rr, cyc;
    bit   err_m;
    int   checks, failures;
    bit   last_hs;
    int   last_w;
    int   nh;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int mwin();
        for (int i = 0; i < N; i++) begin
            if (req[(rr + i) % N]) return (rr + i) % N;
        end
        return 0;
    endfunction

    function automatic bit resp_ready(input int gap);
        return (q.size() > 0) && (q[0].cyc <= cyc - gap);
    endfunction

    // Compare every output against the model, then clock once and update the model
    task automatic step();
        int           w, cnt, s;
        bit           ci, tr, hs, pop;
        logic [N-1:0] eg, ev;
        #1;
        cnt = q.size();
        ci  = (cnt < MAXO) || tgt_rv;
        tr  = (req != '0) && ci;
        w   = mwin();
        hs  = tr && tgt_gnt;
        pop = tgt_rv && (cnt > 0);
        eg  = '0;
        ev  = '0;
        if (hs) eg[w] = 1'b1;
        if (pop) ev[q[0].idx] = 1'b1;
        s = tr ? w : 0;
        chk("tgt_req", 64'(treq), 64'(tr));
        chk("gnt", 64'(gnt), 64'(eg));
        chk("r_valid", 64'(rvalid), 64'(ev));
        chk("tgt_add", 64'(tadd), 64'(add[s]));
        chk("tgt_wen", 64'(twen), 64'(wen[s]));
        chk("tgt_be", 64'(tbe), 64'(be[s]));
        chk("tgt_data", 64'(tdata), 64'(data[s]));
        chk("tgt_id", 64'(tid), 64'(s));
        chk("r_data", 64'(r_data[cyc % N]), 64'(tgt_rdata));
        chk("r_opc", 64'(r_opc), tgt_opc ? 64'(10'h3FF) : 64'd0);
        chk("busy", 64'(busy), 64'(cnt != 0));
        chk("err", 64'(err), 64'(err_m));
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (hs) begin
            q.push_back('{w, cyc});
            rr = (w + 1) % N;
        end
        if (tgt_rv && cnt == 0) err_m = 1'b1;
        last_hs = hs;
        last_w  = w;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        req     = '0;
        tgt_gnt = 1'b0;
        for (int k = 0; k < 30 && q.size() > 0; k++) begin
            tgt_rv = resp_ready(1);
            step();
        end
        tgt_rv = 1'b0;
        chk("drained", 64'(q.size()), 64'd0);
    endtask

    task automatic rand_inputs();
        req       = N'($urandom) & N'($urandom | $urandom);
        wen       = N'($urandom);
        for (int i = 0; i < N; i++) begin
            add[i]  = $urandom;
            data[i] = $urandom;
            be[i]   = 4'($urandom);
        end
        tgt_gnt   = ($urandom % 4) != 0;
        tgt_rv    = resp_ready(1) ? 1'($urandom % 2) : (q.size() == 0 && ($urandom % 40) == 0);
        tgt_rdata = $urandom;
        tgt_opc   = 1'($urandom % 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; rr = 0; cyc = 0; err_m = 1'b0;
        rst_n = 1'b0;
        rand_inputs();
        req = '1; tgt_gnt = 1'b1; tgt_rv = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_treq", 64'(treq), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        tgt_rv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // All initiators requesting, response two cycles after grant
        req = '1; tgt_gnt = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tgt_rv = resp_ready(2);
            step();
            chk("rr_hs", 64'(last_hs), 64'd1);
            chk("rr_seq", 64'(last_w), 64'(i % N));
        end
        drain();

        // Target withholds responses: exactly MAXO grants, then same-cycle bypass
        req = '1; tgt_gnt = 1'b1; tgt_rv = 1'b0; nh = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            nh += int'(last_hs);
        end
        chk("full_grants", 64'(nh), 64'd4);
        tgt_rv = 1'b1;
        step();
        chk("bypass_grant", 64'(last_hs), 64'd1);
        tgt_rv = 1'b0;
        step();
        chk("full_hold", 64'(last_hs), 64'd0);
        drain();

        // Sparse requesters 3 and 7 starting from pointer 8
        req = N'(1) << 7; tgt_gnt = 1'b1; tgt_rv = 1'b0;
        step();
        req = (N'(1) << 3) | (N'(1) << 7);
        for (int i = 0; i < 3; i++) begin
            tgt_rv = resp_ready(1);
            step();
            chk("sparse_seq", 64'(last_w), (i == 1) ? 64'd7 : 64'd3);
        end
        drain();

        // Read from initiator 5 with error response
        req = N'(1) << 5; wen[5] = 1'b1; tgt_gnt = 1'b1;
        step();
        chk("rd5_grant", 64'(last_w), 64'd5);
        req = '0; tgt_gnt = 1'b0; tgt_rv = 1'b1; tgt_rdata = 32'hDEADBEEF; tgt_opc = 1'b1;
        #1;
        chk("rd5_rvalid", 64'(rvalid), 64'(10'b0000100000));
        chk("rd5_data", 64'(r_data[5]), 64'hDEADBEEF);
        chk("rd5_opc", 64'(r_opc[5]), 64'd1);
        step();

        // Spurious response with empty FIFO
        tgt_rv = 1'b1;
        #1;
        chk("spur_rvalid", 64'(rvalid), 64'd0);
        chk("spur_err_pre", 64'(err), 64'd0);
        step();
        tgt_rv = 1'b0;
        #1;
        chk("spur_err", 64'(err), 64'd1);
        for (int i = 0; i < 3; i++) step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step();
        end
        drain();

        // Reset in the middle of traffic with three outstanding
        req = '1; tgt_gnt = 1'b1; tgt_rv = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        tgt_rv = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        chk("mid_rst_gnt", 64'(gnt), 64'd0);
        chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
        chk("mid_rst_treq", 64'(treq), 64'd0);
        q.delete();
        rr = 0; err_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; tgt_rv = 1'b0;
        req = (N'(1) << 4) | (N'(1) << 8);
        step();
        chk("post_rst_grant", 64'(last_w), 64'd4);
        step();
        chk("post_rst_next", 64'(last_w), 64'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmac_ctrl_arbiter.md
Name: dmac_ctrl_arbiter

Overview:
- Round-robin arbiter that funnels NB_INIT control-bus initiators onto one DMA control target port.
- Initiators are the cluster cores, the cluster-control PE and the FC PE.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to its issuing initiator.
- Sits between the peripheral interconnect and the DMA controller's control target, so a single-port DMA configuration is shared fairly.

Parameters:
- NB_INIT, 10, number of initiators (NB_CORES + 2); must be ≥2.
- ADDR_WIDTH, 32, control address width.
- DATA_WIDTH, 32, control data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- MAX_OUTSTANDING, 4, ID FIFO depth; power of 2, ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async reset, active-low
- init_req_i  in  NB_INIT  per-initiator request
- init_add_i  in  NB_INIT×ADDR_WIDTH  address
- init_wen_i  in  NB_INIT  1=read, 0=write
- init_be_i  in  NB_INIT×BE_WIDTH  byte enables
- init_data_i  in  NB_INIT×DATA_WIDTH  write data
- init_gnt_o  out  NB_INIT  grant, one-hot or zero
- init_r_valid_o  out  NB_INIT  response valid, one-hot or zero
- init_r_data_o  out  NB_INIT×DATA_WIDTH  read data, broadcast
- init_r_opc_o  out  NB_INIT  error flag, broadcast
- tgt_req_o  out  1  request to DMA control
- tgt_add_o  out  ADDR_WIDTH  muxed address
- tgt_wen_o  out  1  muxed type
- tgt_be_o  out  BE_WIDTH  muxed byte enables
- tgt_data_o  out  DATA_WIDTH  muxed write data
- tgt_id_o  out  $clog2(NB_INIT)  winner index
- tgt_gnt_i  in  1  target grant
- tgt_r_valid_i  in  1  target response valid
- tgt_r_data_i  in  DATA_WIDTH  target read data
- tgt_r_opc_i  in  1  target error
- busy_o  out  1  outstanding count ≠ 0
- err_o  out  1  sticky: response received with FIFO empty

Behaviour:
- Reset (async, rst_ni=0):
  - rr_ptr=0, FIFO empty, count=0, err_o=0.
  - All grant and response-valid outputs 0; tgt_req_o=0.
- Arbitration (combinational):
  - Winner w = first asserted init_req_i scanning from rr_ptr upward, wrapping modulo NB_INIT.
  - tgt_req_o = |init_req_i & can_issue.
  - can_issue = (count < MAX_OUTSTANDING) | tgt_r_valid_i.
  - tgt_add_o, tgt_wen_o, tgt_be_o, tgt_data_o and tgt_id_o come from w. When tgt_req_o=0 they are don't-care; drive them from index 0.
- Grant: init_gnt_o[w] = tgt_req_o & tgt_gnt_i, zero-latency.
- On handshake (tgt_req_o & tgt_gnt_i):
  - Push w into the FIFO.
  - rr_ptr ← (w+1) mod NB_INIT, wrapping at NB_INIT-1 → 0.
- No handshake: rr_ptr holds. A request deasserting before grant is legal; the winner is re-evaluated every cycle.
- Response:
  - The target answers in issue order, at least one cycle after its grant.
  - On tgt_r_valid_i with count>0: init_r_valid_o[head]=1 in the same cycle, then pop.
  - r_data and r_opc pass through combinationally to all initiators.
- Simultaneous push and pop: count unchanged. Push and pop are legal when full, via the can_issue bypass.
- Error case, tgt_r_valid_i with count=0:
  - No init_r_valid_o asserted.
  - err_o set; it clears only on reset.
- Full, no pop: tgt_req_o=0, no grants, rr_ptr frozen.
- count width is $clog2(MAX_OUTSTANDING)+1. Read/write pointers wrap modulo MAX_OUTSTANDING.
- busy_o is registered-state derived, with no combinational input path: busy_o = (count≠0).

Decomposition:
- Package dmac_arb_pkg holds:
  - localparam IDX_W = $clog2(NB_INIT), via a function taking NB_INIT;
  - typedef init_idx_t;
  - typedef ctrl_req_t {add, wen, be, data}.
- Sub-module dmac_arb_id_fifo:
  - synchronous FIFO of init_idx_t, depth MAX_OUTSTANDING;
  - ports push/pop/head/count/full/empty.
- The round-robin priority scan stays inline.

Test Plan:
- Reset mid-traffic: assert rst_ni=0 with count=3 → busy_o=0, err_o=0, all init_gnt_o/r_valid_o 0 immediately; first post-reset grant goes to the lowest requester ≥ index 0.
- All 10 requesting, tgt_gnt_i=1 every cycle, response 2 cycles later → grants 0,1,…,9,0 on successive cycles; each response is routed to its issuer in order.
- MAX_OUTSTANDING=4, target withholds r_valid → exactly 4 grants, then tgt_req_o=0.
  - A single r_valid in cycle k allows a grant in the same cycle k.
  - count stays 4.
- Only initiators 3 and 7 requesting, rr_ptr=8 → grant 3, then 7, then 3; rr_ptr values 4, 8, 4.
- Read from initiator 5 with tgt_r_data_i=0xDEADBEEF, r_opc=1 → init_r_valid_o=10'b0000100000, init_r_data_o=0xDEADBEEF, init_r_opc_o=1.
- Spurious tgt_r_valid_i with FIFO empty → no init_r_valid_o; err_o=1 next cycle and stays 1 until reset.
